// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronizer, press/release debounce,
// long-press detection with auto-repeat, and a stretched IRQ pulse.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter int unsigned LONG_CYCLES     = 32'd50000000,
  parameter int unsigned REPEAT_CYCLES   = 32'd12500000,
  parameter int unsigned IRQ_STRETCH     = 32'd4,
  parameter bit          IRQ_ON_REPEAT   = 1'b1
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic key_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic irq_out
);

  localparam int unsigned DBW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW =
    (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int unsigned RW =
    (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int unsigned SW = $clog2(IRQ_STRETCH + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH = SW'(IRQ_STRETCH);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    HELD,
    DB_RELEASE
  } state_e;

  state_e         state_q, state_d;
  logic           sync1_q, sync_n_q;
  logic           ret_held_q, ret_held_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
  logic [SW-1:0]  irq_cnt_q, irq_cnt_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           long_q, long_d;
  logic           repeat_q, repeat_d;
  logic           irq_fire;

  always_comb begin
    state_d    = state_q;
    ret_held_d = ret_held_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!sync_n_q) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (sync_n_q) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
      PRESSED: begin
        if (sync_n_q) begin
          state_d    = DB_RELEASE;
          ret_held_d = 1'b0;
          db_cnt_d   = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = HELD;
          rep_cnt_d = '0;
          long_d    = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      HELD: begin
        if (sync_n_q) begin
          state_d    = DB_RELEASE;
          ret_held_d = 1'b1;
          db_cnt_d   = '0;
        end else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          repeat_d  = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
      DB_RELEASE: begin
        // a bounce back to pressed resumes with frozen hold/repeat counts
        if (!sync_n_q) begin
          state_d = ret_held_q ? HELD : PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign irq_fire = press_d | (IRQ_ON_REPEAT & repeat_d);

  always_comb begin
    irq_cnt_d = irq_cnt_q;
    if (irq_fire) begin
      irq_cnt_d = STRETCH;
    end else if (irq_cnt_q != '0) begin
      irq_cnt_d = irq_cnt_q - SW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q    <= 1'b1;
      sync_n_q   <= 1'b1;
      state_q    <= IDLE;
      ret_held_q <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      irq_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync1_q    <= key_n;
      sync_n_q   <= sync1_q;
      state_q    <= state_d;
      ret_held_q <= ret_held_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      irq_cnt_q  <= irq_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign btn_level = (state_q == PRESSED) ||
                     (state_q == HELD) ||
                     (state_q == DB_RELEASE);
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign irq_out       = (irq_cnt_q != '0);

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: run-length reference model,
// directed scenarios, then randomized key/reset activity.
module tb_key_conditioner;

  localparam int D  = 4;
  localparam int LG = 20;
  localparam int RP = 8;
  localparam int ST = 3;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       btn;
    logic [3:0] strb;
    logic       irq;
    logic       irq0;
  } lv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_n = 1'b1;
  logic btn, prs, rel, lng, rpt, irq;
  logic btn0, prs0, rel0, lng0, rpt0, irq0;

  int cyc = 0;
  int checks = 0;
  int errs = 0;
  int last_drive = 0;
  int first_seen[4] = '{-1, -1, -1, -1};

  ev_t evq[$];
  lv_t lvq[$];

  // reference model state
  bit h1 = 1'b1, h2 = 1'b1, prev_sy = 1'b1;
  bit lvl = 1'b0, long_done = 1'b0;
  int run0 = 0, run1 = 0, hold_n = 0, rep_n = 0;
  int irq_left = 0, irq0_left = 0;

  key_conditioner #(
    .DEBOUNCE_CYCLES(D), .LONG_CYCLES(LG),
    .REPEAT_CYCLES(RP), .IRQ_STRETCH(ST),
    .IRQ_ON_REPEAT(1'b1)
  ) u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .key_n(key_n),
    .btn_level(btn), .press_pulse(prs),
    .release_pulse(rel), .long_pulse(lng),
    .repeat_pulse(rpt), .irq_out(irq)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(D), .LONG_CYCLES(LG),
    .REPEAT_CYCLES(RP), .IRQ_STRETCH(ST),
    .IRQ_ON_REPEAT(1'b0)
  ) u_dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .key_n(key_n),
    .btn_level(btn0), .press_pulse(prs0),
    .release_pulse(rel0), .long_pulse(lng0),
    .repeat_pulse(rpt0), .irq_out(irq0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 4; i++) first_seen[i] = -1;
  endtask

  // Model: sync is the key delayed two cycles; a press is a run of
  // D+1 low samples while released, a release D+1 high samples while
  // pressed; hold/repeat time counts only low samples whose previous
  // sample was also low.
  task automatic model(input bit k, input bit r);
    bit sy;
    logic [3:0] s;
    lv_t l;
    ev_t e;
    s = 4'b0;
    if (!r) begin
      h1 = 1'b1; h2 = 1'b1; prev_sy = 1'b1;
      lvl = 1'b0; long_done = 1'b0;
      run0 = 0; run1 = 0; hold_n = 0; rep_n = 0;
      irq_left = 0; irq0_left = 0;
    end else begin
      sy = h2; h2 = h1; h1 = k;
      run0 = sy ? 0 : run0 + 1;
      run1 = sy ? run1 + 1 : 0;
      if (!lvl) begin
        if (run0 == D + 1) begin
          s[0] = 1'b1; lvl = 1'b1;
          hold_n = 0; rep_n = 0; long_done = 1'b0;
        end
      end else begin
        if (!prev_sy && !sy) begin
          if (!long_done) begin
            hold_n++;
            if (hold_n == LG) begin
              s[2] = 1'b1; long_done = 1'b1; rep_n = 0;
            end
          end else begin
            rep_n++;
            if (rep_n == RP) begin
              s[3] = 1'b1; rep_n = 0;
            end
          end
        end
        if (run1 == D + 1) begin
          s[1] = 1'b1; lvl = 1'b0;
        end
      end
      prev_sy = sy;
      if (s[0] || s[3]) irq_left = ST;
      else if (irq_left > 0) irq_left--;
      if (s[0]) irq0_left = ST;
      else if (irq0_left > 0) irq0_left--;
    end
    l.cyc = cyc + 1; l.btn = lvl; l.strb = s;
    l.irq = (irq_left > 0); l.irq0 = (irq0_left > 0);
    lvq.push_back(l);
    if (s != 4'b0) begin
      e.cyc = cyc + 1; e.kind = s;
      evq.push_back(e);
    end
  endtask

  task automatic step(input bit k, input bit r);
    @(negedge clk);
    key_n = k;
    rst_n = r;
    last_drive = cyc;
    model(k, r);
  endtask

  task automatic hold(input bit k, input int n);
    repeat (n) step(k, 1'b1);
  endtask

  initial begin : monitor
    lv_t l;
    ev_t e;
    logic [3:0] sd;
    forever begin
      @(posedge clk);
      #2;
      sd = {rpt, lng, rel, prs};
      if (lvq.size() > 0 && lvq[0].cyc == cyc) begin
        l = lvq.pop_front();
        chk("btn_level", btn, l.btn);
        chk("irq_out", irq, l.irq);
        chk("irq_out_norepeat", irq0, l.irq0);
        chk("dut0_outputs", {btn0, rpt0, lng0, rel0, prs0},
            {l.btn, l.strb});
        chk("strobe_onehot", $onehot0(sd), 1);
      end
      if (sd != 4'b0) begin
        for (int i = 0; i < 4; i++)
          if (sd[i] && first_seen[i] < 0) first_seen[i] = cyc;
        if (evq.size() == 0) begin
          chk("spurious_event", sd, 0);
        end else begin
          e = evq.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_kind", sd, e.kind);
        end
      end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
        e = evq.pop_front();
        chk("missing_event", 0, e.kind);
      end
    end
  end

  initial begin : stim
    int t0, t1, n;
    bit v;
    repeat (3) step(1'b1, 1'b0);
    chk("reset_outputs", {btn, prs, rel, lng, rpt, irq}, 0);
    hold(1'b1, 5);

    // clean press, long press, repeats, release
    clear_seen();
    hold(1'b0, 1); t0 = last_drive;
    hold(1'b0, 59);
    hold(1'b1, 1); t1 = last_drive;
    hold(1'b1, 19);
    chk("clean_press_cycle", first_seen[0], t0 + D + 3);
    chk("long_cycle", first_seen[2], t0 + D + 3 + LG);
    chk("first_repeat_cycle", first_seen[3], t0 + D + 3 + LG + RP);
    chk("release_cycle", first_seen[1], t1 + D + 3);

    // bounce rejected
    clear_seen();
    hold(1'b0, 3); hold(1'b1, 1); hold(1'b0, 3); hold(1'b1, 20);
    chk("bounce_no_press", first_seen[0], -1);
    chk("bounce_no_release", first_seen[1], -1);

    // release glitch while held delays the repeat schedule
    clear_seen();
    hold(1'b0, 1); t0 = last_drive;
    hold(1'b0, 29); hold(1'b1, 2); hold(1'b0, 28);
    hold(1'b1, 1); t1 = last_drive;
    hold(1'b1, 19);
    chk("glitch_long_cycle", first_seen[2], t0 + 27);
    chk("glitch_repeat_cycle", first_seen[3], t0 + 38);
    chk("glitch_release_cycle", first_seen[1], t1 + D + 3);

    // reset mid-press with the key still held
    clear_seen();
    hold(1'b0, 1); t0 = last_drive;
    hold(1'b0, 9);
    chk("pre_reset_level", btn, 1);
    step(1'b0, 1'b0);
    #1;
    chk("async_reset_outputs", {btn, prs, rel, lng, rpt, irq}, 0);
    step(1'b0, 1'b0);
    clear_seen();
    step(1'b0, 1'b1); t1 = last_drive;
    hold(1'b0, 20);
    chk("repress_cycle", first_seen[0], t1 + D + 3);
    chk("no_release_after_reset", first_seen[1], -1);
    hold(1'b1, 15);

    // randomized key activity with occasional resets
    for (int seg = 0; seg < 200; seg++) begin
      n = $urandom_range(0, 9);
      v = 1'($urandom_range(0, 1));
      if (n == 0) begin
        repeat ($urandom_range(1, 2)) step(v, 1'b0);
      end else if (n < 5) begin
        hold(v, $urandom_range(1, D + 2));
      end else begin
        hold(v, $urandom_range(5, 80));
      end
    end

    hold(1'b1, 30);
    repeat (3) @(negedge clk);
    chk("events_drained", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule
